// File: rtl/skolem_chk_pkg.sv
// Shared types and helpers for the Skolem bvuge/bvmul conformance checker.
package skolem_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_EVAL0,
        ST_EVAL1,
        ST_CHECK,
        ST_DONE
    } chk_state_t;

    localparam int DEF_W          = 4;
    localparam int DEF_LAT        = 0;
    localparam int VEC_W          = 2 * DEF_W;
    // Cycles spent on one input vector with the default width and latency.
    localparam int CYCLES_PER_VEC = DEF_LAT + 2 + 2 * DEF_W;

    // Unsigned greater-or-equal; callers zero-extend their W-bit operands.
    function automatic logic uge_w(input logic [31:0] a, input logic [31:0] b);
        return a >= b;
    endfunction

endpackage

// File: rtl/skolem_serial_mul.sv
// Truncating LSB-first shift-add multiplier; product is valid exactly W cycles after start.
module skolem_serial_mul #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;

    // The start cycle performs the first partial product; W-1 more steps follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            cnt    <= CW'(W - 1);
            busy   <= (W > 1);
            done   <= (W == 1);
        end else if (busy) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            busy   <= (cnt != CW'(1));
            done   <= (cnt == CW'(1));
        end else begin
            done   <= 1'b0;
        end
    end

    assign product = acc;

endmodule

// File: rtl/skolem_uge_mul_checker.sv
// Exhaustively drives a 1-bit Skolem netlist and checks it against uge(trunc(S*k), T).
module skolem_uge_mul_checker
    import skolem_chk_pkg::*;
#(
    parameter int W            = 4,
    parameter int SKOLEM_LAT   = 0,
    parameter int STOP_ON_FAIL = 0,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [2*W-1:0]   vec_o,
    input  logic             skolem_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             cex_valid,
    output logic [2*W-1:0]   cex_vec,
    output logic             cex_k
);
    localparam int VW = 2 * W;

    chk_state_t   state_q, state_d;
    logic [7:0]   cnt_q;
    logic         k_q;
    logic         f0_q;
    logic         mul_start, mul_busy, mul_done;
    logic [W-1:0] mul_a, product;
    logic [W-1:0] s_op, t_op;
    logic         f1, fail, last_vec, apply_last, phase_last;

    assign s_op       = vec_o[W-1:0];
    assign t_op       = vec_o[VW-1:W];
    assign apply_last = (cnt_q == 8'(SKOLEM_LAT));
    assign phase_last = (cnt_q == 8'(W - 1));
    assign last_vec   = &vec_o;

    // The multiplier is restarted on the first cycle of each EVAL phase: k-candidate 0, then 1.
    assign mul_start  = ((state_q == ST_EVAL0) || (state_q == ST_EVAL1)) && (cnt_q == 8'd0);
    assign mul_a      = (state_q == ST_EVAL1) ? W'(1) : '0;

    // In CHECK the multiplier holds S*1, so f1 is formed combinationally there.
    assign f1   = uge_w(32'(product), 32'(t_op));
    assign fail = (f0_q | f1) & ~(k_q ? f1 : f0_q);

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);
    assign pass = (state_q == ST_DONE) && (fail_count == '0);

    skolem_serial_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (s_op),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides everything, start only counts when idle or done.
    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
                ST_APPLY:         if (apply_last) state_d = ST_EVAL0;
                ST_EVAL0:         if (phase_last) state_d = ST_EVAL1;
                ST_EVAL1:         if (phase_last) state_d = ST_CHECK;
                ST_CHECK:         state_d = (last_vec || (fail && (STOP_ON_FAIL != 0))) ? ST_DONE : ST_APPLY;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Phase cycle counter; restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt_q <= '0;
        else if (state_d != state_q) cnt_q <= '0;
        else                         cnt_q <= cnt_q + 1'b1;
    end

    // Vector, sampled Skolem bit, f0 and the run results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o      <= '0;
            k_q        <= 1'b0;
            f0_q       <= 1'b0;
            fail_count <= '0;
            cex_valid  <= 1'b0;
            cex_vec    <= '0;
            cex_k      <= 1'b0;
        end else if (abort) begin
            vec_o <= '0;
        end else if (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start) begin
            vec_o      <= '0;
            fail_count <= '0;
            cex_valid  <= 1'b0;
            cex_vec    <= '0;
            cex_k      <= 1'b0;
        end else begin
            if ((state_q == ST_APPLY) && apply_last) k_q <= skolem_i;
            if ((state_q == ST_EVAL1) && mul_done && !mul_busy) f0_q <= uge_w(32'(product), 32'(t_op));
            if (state_q == ST_CHECK) begin
                if (fail) begin
                    if (fail_count != '1) fail_count <= fail_count + 1'b1;
                    if (!cex_valid) begin
                        cex_valid <= 1'b1;
                        cex_vec   <= vec_o;
                        cex_k     <= k_q;
                    end
                end
                if (state_d == ST_APPLY) vec_o <= vec_o + 1'b1;
            end
        end
    end

endmodule

// File: doc/skolem_uge_mul_checker.md
Name: skolem_uge_mul_checker

Overview:
- Sequential conformance checker that sits directly downstream of a synthesized 1-bit Skolem function for the `bvuge`/`bvmul` formula family. The Skolem function has 8 inputs and 1 output.
- Enumerates every input vector, drives it to the Skolem netlist, and samples the returned bit.
- Independently evaluates the formula using a bit-serial multiplier and reports pass/fail, a failure count and the first counterexample.
- Used on FPGA/emulation to sign off each generated Skolem netlist.

Parameters:
- W, 4: operand width. The vector is 2W bits; S = v[W-1:0], T = v[2W-1:W].
- SKOLEM_LAT, 0: cycles from `vec_o` change to a valid `skolem_i`. Range 0..7.
- STOP_ON_FAIL, 0: 1 = enter DONE at the first failing vector.
- CNT_W, 16: width of `fail_count`.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: 1-cycle pulse, honoured only in IDLE or DONE.
- abort, in, 1: forces IDLE next cycle from any state.
- vec_o, out, 2W: vector driven to the Skolem inputs (i0 = bit 0).
- skolem_i, in, 1: Skolem output k.
- busy, out, 1: high in any state other than IDLE/DONE.
- done, out, 1: high while in DONE.
- pass, out, 1: valid when `done`; 1 iff `fail_count` == 0.
- fail_count, out, CNT_W: number of failing vectors; saturates at all-ones.
- cex_valid, out, 1: set on the first failure of a run.
- cex_vec, out, 2W: vector of the first failure.
- cex_k, out, 1: `skolem_i` sampled at the first failure.

Behaviour:
- Formula: F(v,k) = uge(trunc_W(S * zext(k)), T). The Skolem bit is correct for v iff (F(v,0) or F(v,1)) implies F(v,k).
- Reset values: state=IDLE, vec_o=0, busy=0, done=0, pass=0, fail_count=0, cex_valid=0, cex_vec=0, cex_k=0.
- States: IDLE, APPLY, EVAL0, EVAL1, CHECK, DONE.
  - IDLE/DONE + start: clear fail_count/cex_*, set vec_o=0, go to APPLY.
  - APPLY: lasts SKOLEM_LAT+1 cycles. `skolem_i` is registered on the last cycle. Then go to EVAL0.
  - EVAL0: W cycles of shift-add for S*0. At exit, f0 = uge(product, T).
  - EVAL1: W cycles for S*1. At exit, f1 = uge(product, T).
  - CHECK: 1 cycle.
    - fail = (f0|f1) & ~(k ? f1 : f0).
    - On fail: increment fail_count (saturating). If cex_valid=0, capture cex_vec/cex_k and set cex_valid.
    - If vec_o is all-ones, or (fail & STOP_ON_FAIL): go to DONE.
    - Otherwise: vec_o+1 and go to APPLY.
- Cycles per vector = SKOLEM_LAT + 2 + 2W. With defaults that is 10; a full run is 256*10 = 2560 cycles from start to done.
- vec_o is held stable from APPLY entry through CHECK.
- Wrap-around: vec_o never wraps; all-ones is the terminal vector.
- start while busy: ignored. abort and start in the same cycle: abort wins.
- Mid-run reset: asynchronous return to reset values; no partial result retained.
- abort: returns to IDLE and zeroes vec_o. fail_count/cex_* keep their values; pass/done drop to 0.
- DONE: outputs held until start or abort.
- Multiplier: truncating shift-add. Multiplicand is zext(k-candidate) and multiplier is S, LSB first. The W-bit accumulator drops carries beyond W.

Decomposition:
- Package `skolem_chk_pkg`:
  - state enum `chk_state_t`.
  - function `uge_w`.
  - `localparam VEC_W = 2*W`.
  - per-vector cycle-count constant for the bench.
- Sub-module `skolem_serial_mul`: ports start, a, b, busy, done, product. Latency exactly W cycles. It is reused for both EVAL0 and EVAL1.

Test Plan:
- Golden Skolem model k=1 constant, defaults -> done after 2560 cycles, pass=1, fail_count=0, cex_valid=0.
- Stuck-at-0 Skolem -> fail_count=120 (pairs with S>=T and T!=0), cex_vec=8'h11 (S=1,T=1), cex_k=0, pass=0.
- Same stuck-at-0 with STOP_ON_FAIL=1 -> DONE after vector 8'h11 (18 vectors, 180 cycles), fail_count=1.
- SKOLEM_LAT=3 with a registered golden model delayed 3 cycles -> pass=1, done at cycle 256*13=3328. SKOLEM_LAT=3 with an undelayed wrong model -> fails are still detected.
- abort asserted at cycle 500, then start at cycle 510 -> busy low at 501, vec_o=0; rerun completes with correct fail_count.
- rst_n low for 1 cycle mid-EVAL1 -> all outputs at reset values immediately; no activity until start.
